simon_playback_sequencer: RTL

SIMON_PLAYBACK_SEQUENCER -- requirements
Module: simon_playback_sequencer

---
 rtl/simon_playback_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/simon_playback_sequencer.sv
// Simon playback sequencer: stores a pseudo-random color sequence and
// plays it back as timed tones, plus result jingles and button echo.
module simon_playback_sequencer #(
  parameter int TONE_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int JINGLE_CYCLES = 100_000_000,
  parameter int MAX_LEN       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        play_req,
  input  logic        append_req,
  input  logic        clear_req,
  input  logic        result_req,
  input  logic        result_pass,
  input  logic        btn_valid,
  input  logic [1:0]  btn_color,
  input  logic [3:0]  rd_idx,
  output logic [1:0]  rd_color,
  output logic        enable,
  output logic [1:0]  tone_select,
  output logic        success,
  output logic        failure,
  output logic        busy,
  output logic        done,
  output logic [4:0]  seq_len,
  output logic        full
);

  typedef enum logic [2:0] {
    IDLE,
    TONE,
    GAP,
    JINGLE,
    ECHO
  } state_t;

  localparam logic [26:0] TONE_L = 27'(TONE_CYCLES);
  localparam logic [26:0] GAP_L  = 27'(GAP_CYCLES);
  localparam logic [26:0] JING_L = 27'(JINGLE_CYCLES);
  localparam logic [4:0]  MAXL   = 5'(MAX_LEN);

  state_t      state_q;
  logic [26:0] cnt_q;
  logic [3:0]  step_q;
  logic [4:0]  len_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        en_q;
  logic [1:0]  sel_q;
  logic        succ_q;
  logic        fail_q;
  logic        done_q;
  logic [1:0]  mem_q [16];

  logic        wr_en;
  logic [4:0]  step_inc;
  logic [3:0]  step_nx;
  logic        last;

  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign full     = (len_q == MAXL);
  assign step_inc = {1'b0, step_q} + 5'd1;
  assign step_nx  = step_q + 4'd1;
  assign last     = (step_inc >= len_q);

  // append only wins in IDLE when no higher-priority request is present
  assign wr_en = (state_q == IDLE) && append_req && !result_req &&
                 !play_req && !clear_req && !full;

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[len_q[3:0]] <= lfsr_q[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= (seed == 16'd0) ? 16'hACE1 : seed;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (result_req) begin
            state_q <= JINGLE;
            cnt_q   <= JING_L;
            succ_q  <= result_pass;
            fail_q  <= !result_pass;
          end else if (play_req) begin
            if (len_q == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= TONE;
              cnt_q   <= TONE_L;
              step_q  <= '0;
              en_q    <= 1'b1;
              sel_q   <= mem_q[0];
            end
          end else if (clear_req) begin
            len_q <= '0;
          end else if (append_req) begin
            if (wr_en) len_q <= len_q + 5'd1;
          end else if (btn_valid) begin
            state_q <= ECHO;
            en_q    <= 1'b1;
            sel_q   <= btn_color;
          end
        end
        TONE: begin
          if (cnt_q == 27'd1) begin
            state_q <= GAP;
            cnt_q   <= GAP_L;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 27'd1;
          end
        end
        GAP: begin
          if (cnt_q == 27'd1) begin
            if (last) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= TONE;
              cnt_q   <= TONE_L;
              step_q  <= step_nx;
              en_q    <= 1'b1;
              sel_q   <= mem_q[step_nx];
            end
          end else begin
            cnt_q <= cnt_q - 27'd1;
          end
        end
        JINGLE: begin
          if (cnt_q == 27'd1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            succ_q  <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 27'd1;
          end
        end
        ECHO: begin
          if (btn_valid) begin
            sel_q <= btn_color;
          end else begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_color    = mem_q[rd_idx];
  assign enable      = en_q;
  assign tone_select = sel_q;
  assign success     = succ_q;
  assign failure     = fail_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign seq_len     = len_q;

endmodule
